// File: rtl/ccff_loader.sv
// ccff_loader
// Writes a byte-wide bitstream into the fabric configuration chain
// (ccff_head -> ccff_tail). It then recirculates the chain once so the
// configuration is kept. During that pass it compares a CRC-16-CCITT of the
// bits written with a CRC of the bits read back.
//
// Ports
//   prog_clk      : programming clock, all state on the rising edge
//   prog_reset_n  : asynchronous active-low reset
//   start         : begin a load (sampled only while idle)
//   s_data        : bitstream byte, bit 0 is shifted first
//   s_valid       : s_data valid
//   s_ready       : byte accepted this cycle when s_valid is also high
//   ccff_head     : serial data into the chain
//   ccff_shift_en : chain shifts on the next prog_clk edge when high
//   ccff_tail     : serial data out of the chain
//   busy          : high while loading or checking
//   done          : one-cycle pulse when the readback check ends
//   pass          : CRC match result, valid from done until the next start

module ccff_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic       prog_clk,
  input  logic       prog_reset_n,
  input  logic       start,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       ccff_head,
  output logic       ccff_shift_en,
  input  logic       ccff_tail,
  output logic       busy,
  output logic       done,
  output logic       pass
);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;

  state_t           state_q, state_d;
  logic [7:0]       shiftBuf_q, shiftBuf_d;
  logic [3:0]       bcnt_q, bcnt_d;
  logic [CNT_W-1:0] bitsIssued_q, bitsIssued_d;
  logic [15:0]      crcWr_q, crcWr_d;
  logic [15:0]      crcRd_q, crcRd_d;
  logic             shiftEn_q, shiftEn_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             shiftNow;
  logic             accept;
  logic [CNT_W-1:0] issuedNext;
  logic [CNT_W-1:0] remain;

  // One MSB-first step of CRC-16-CCITT (poly 0x1021)
  function automatic logic [15:0] crcStep(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // bitsIssued counts shifted bits; issuedNext includes the shift happening now,
  // so the bcnt==1 overlap accepts the next byte without a bubble.
  assign shiftNow   = (bcnt_q != 4'd0);
  assign issuedNext = bitsIssued_q + CNT_W'(shiftNow);
  assign remain     = CNT_W'(CHAIN_LEN) - issuedNext;
  assign s_ready    = (state_q == LOAD) && (bcnt_q <= 4'd1) &&
                      (issuedNext < CNT_W'(CHAIN_LEN));
  assign accept     = s_ready && s_valid;

  always_comb begin
    state_d      = state_q;
    shiftBuf_d   = shiftBuf_q;
    bcnt_d       = bcnt_q;
    bitsIssued_d = bitsIssued_q;
    crcWr_d      = crcWr_q;
    crcRd_d      = crcRd_q;
    pass_d       = pass_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = LOAD;
          shiftBuf_d   = 8'h00;
          bcnt_d       = 4'd0;
          bitsIssued_d = '0;
          crcWr_d      = 16'hFFFF;
          crcRd_d      = 16'hFFFF;
          pass_d       = 1'b0;
        end
      end

      LOAD: begin
        if (shiftNow) begin
          shiftBuf_d   = {1'b0, shiftBuf_q[7:1]};
          bcnt_d       = bcnt_q - 4'd1;
          bitsIssued_d = issuedNext;
          crcWr_d      = crcStep(crcWr_q, shiftBuf_q[0]);
        end
        // A final byte only loads as many bits as the chain still needs
        if (accept) begin
          shiftBuf_d = s_data;
          bcnt_d     = (32'(remain) >= 32'd8) ? 4'd8 : 4'(remain);
        end
        // The counter is reused to time the readback pass.
        // The buffer is cleared so ccff_head rests low.
        if (shiftNow && (issuedNext == CNT_W'(CHAIN_LEN))) begin
          state_d      = CHECK;
          bitsIssued_d = '0;
          shiftBuf_d   = 8'h00;
        end
      end

      CHECK: begin
        crcRd_d      = crcStep(crcRd_q, ccff_tail);
        bitsIssued_d = bitsIssued_q + CNT_W'(1);
        if (bitsIssued_q == CNT_W'(CHAIN_LEN - 1)) begin
          state_d      = IDLE;
          bitsIssued_d = '0;
          done_d       = 1'b1;
          pass_d       = (crcStep(crcRd_q, ccff_tail) == crcWr_q);
        end
      end

      default: state_d = IDLE;
    endcase

    // Enable is registered from next state so the clock gate sees a clean level
    shiftEn_d = ((state_d == LOAD) && (bcnt_d != 4'd0)) || (state_d == CHECK);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q      <= IDLE;
      shiftBuf_q   <= 8'h00;
      bcnt_q       <= 4'd0;
      bitsIssued_q <= '0;
      crcWr_q      <= 16'hFFFF;
      crcRd_q      <= 16'hFFFF;
      shiftEn_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shiftBuf_q   <= shiftBuf_d;
      bcnt_q       <= bcnt_d;
      bitsIssued_q <= bitsIssued_d;
      crcWr_q      <= crcWr_d;
      crcRd_q      <= crcRd_d;
      shiftEn_q    <= shiftEn_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  // While checking, the tail is fed straight back to the head to recirculate
  assign ccff_head     = (state_q == CHECK) ? ccff_tail : shiftBuf_q[0];
  assign ccff_shift_en = shiftEn_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;

endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader
// Drives two loaders (20-flop and 8-flop chains), each with a behavioural
// shift-chain model. Results are checked against hand-computed expectations.

module tb_ccff_loader;

  localparam int LEN_A = 20;
  localparam int LEN_B = 8;

  logic clk = 1'b0;
  logic rstN;

  always #5 clk = ~clk;

  logic       startA, sValidA, sReadyA, headA, shiftEnA, tailA, busyA, doneA, passA;
  logic [7:0] sDataA;
  logic       startB, sValidB, sReadyB, headB, shiftEnB, tailB, busyB, doneB, passB;
  logic [7:0] sDataB;

  ccff_loader #(.CHAIN_LEN(LEN_A)) dutA (
    .prog_clk(clk), .prog_reset_n(rstN), .start(startA),
    .s_data(sDataA), .s_valid(sValidA), .s_ready(sReadyA),
    .ccff_head(headA), .ccff_shift_en(shiftEnA), .ccff_tail(tailA),
    .busy(busyA), .done(doneA), .pass(passA)
  );

  ccff_loader #(.CHAIN_LEN(LEN_B)) dutB (
    .prog_clk(clk), .prog_reset_n(rstN), .start(startB),
    .s_data(sDataB), .s_valid(sValidB), .s_ready(sReadyB),
    .ccff_head(headB), .ccff_shift_en(shiftEnB), .ccff_tail(tailB),
    .busy(busyB), .done(doneB), .pass(passB)
  );

  // Chain models: head enters the top flop, tail is flop 0, so after a full
  // load bit i of the stream sits in flop i. stuck7 pins flop 7 to zero.
  logic [LEN_A-1:0] chainA = '0;
  logic [LEN_A-1:0] nxtA;
  logic [LEN_B-1:0] chainB = '0;
  logic             stuck7 = 1'b0;

  always_comb begin
    nxtA = {headA, chainA[LEN_A-1:1]};
    if (stuck7) nxtA[7] = 1'b0;
  end

  always @(posedge clk) begin
    if (shiftEnA) chainA <= nxtA;
    if (shiftEnB) chainB <= {headB, chainB[LEN_B-1:1]};
  end

  assign tailA = chainA[0];
  assign tailB = chainB[0];

  int errors = 0;
  int checks = 0;

  logic [7:0] streamA [3];
  int         gapA;
  int         pulseAt;

  int   resDoneCycle, resDoneCount, resStalls, resShifts;
  logic resPass, resPassLater, resBusyLater, resBusy1, resReady1;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Byte driver for loader A; gapA > 0 holds s_valid low for that many cycles
  // after the loader starts asking for the next byte
  task automatic driveA();
    int w;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sValidA = 1'b1;
      sDataA  = streamA[i];
      w = 0;
      while (!sReadyA && w < 100) begin
        @(negedge clk);
        w++;
      end
      checkOutput("acceptReady", 32'(sReadyA), 32'd1);
      @(negedge clk);
      sValidA = 1'b0;
      if (gapA > 0 && i < 2) begin
        w = 0;
        while (!sReadyA && w < 100) begin
          @(negedge clk);
          w++;
        end
        repeat (gapA) @(negedge clk);
      end
    end
  endtask

  // Cycle-by-cycle observer for loader A; cycle 1 is the first after start
  task automatic monitorA();
    int cyc;
    cyc = 0;
    resDoneCycle = 0;
    resDoneCount = 0;
    resStalls    = 0;
    resShifts    = 0;
    resPass      = 1'bx;
    while (cyc < 400 && (resDoneCycle == 0 || cyc < resDoneCycle + 5)) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        resBusy1  = busyA;
        resReady1 = sReadyA;
      end
      startA = (cyc != 1) && (cyc == pulseAt);
      if (busyA && !shiftEnA) resStalls++;
      if (shiftEnA) resShifts++;
      if (doneA) begin
        resDoneCount++;
        if (resDoneCycle == 0) begin
          resDoneCycle = cyc;
          resPass      = passA;
        end
      end
    end
    resPassLater = passA;
    resBusyLater = busyA;
  endtask

  task automatic applyStimulus(input int gap, input int pulse);
    gapA    = gap;
    pulseAt = pulse;
    @(negedge clk);
    startA = 1'b1;
    fork
      driveA();
      monitorA();
    join
  endtask

  initial begin
    int   cyc;
    int   readyCnt;
    int   shiftCnt;
    int   doneCyc;
    logic passAtDone;

    rstN    = 1'b0;
    startA  = 1'b0;
    sValidA = 1'b0;
    sDataA  = 8'h00;
    startB  = 1'b0;
    sValidB = 1'b0;
    sDataB  = 8'h00;
    streamA = '{8'hA5, 8'h3C, 8'h0F};

    #12;
    checkOutput("rstReady", 32'(sReadyA), 32'd0);
    checkOutput("rstHead", 32'(headA), 32'd0);
    checkOutput("rstShiftEn", 32'(shiftEnA), 32'd0);
    checkOutput("rstBusy", 32'(busyA), 32'd0);
    checkOutput("rstDone", 32'(doneA), 32'd0);
    checkOutput("rstPass", 32'(passA), 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    // Back-to-back stream: 20 bits 0xF3CA5, done at 2*20+2
    applyStimulus(0, 0);
    checkOutput("b2bBusyCycle1", 32'(resBusy1), 32'd1);
    checkOutput("b2bReadyCycle1", 32'(resReady1), 32'd1);
    checkOutput("b2bDoneCycle", 32'(resDoneCycle), 32'd42);
    checkOutput("b2bDoneCount", 32'(resDoneCount), 32'd1);
    checkOutput("b2bShifts", 32'(resShifts), 32'd40);
    checkOutput("b2bIdleLoad", 32'(resStalls), 32'd1);
    checkOutput("b2bPass", 32'(resPass), 32'd1);
    checkOutput("b2bPassHeld", 32'(resPassLater), 32'd1);
    checkOutput("b2bChain", 32'(chainA), 32'h000F3CA5);

    // Two 5-cycle stalls: ten extra stall cycles, done moves out by ten
    applyStimulus(5, 0);
    checkOutput("gapDoneCycle", 32'(resDoneCycle), 32'd52);
    checkOutput("gapStalls", 32'(resStalls), 32'd11);
    checkOutput("gapShifts", 32'(resShifts), 32'd40);
    checkOutput("gapPass", 32'(resPass), 32'd1);
    checkOutput("gapChain", 32'(chainA), 32'h000F3CA5);

    // Flop 7 stuck at zero with an all-ones stream must be caught
    stuck7  = 1'b1;
    streamA = '{8'hFF, 8'hFF, 8'hFF};
    applyStimulus(0, 0);
    checkOutput("stuckPass", 32'(resPass), 32'd0);
    checkOutput("stuckDoneCycle", 32'(resDoneCycle), 32'd42);
    checkOutput("stuckShifts", 32'(resShifts), 32'd40);
    stuck7  = 1'b0;
    streamA = '{8'hA5, 8'h3C, 8'h0F};

    // start pulsed in the middle of the readback pass is ignored
    applyStimulus(0, 30);
    checkOutput("ignStartDoneCount", 32'(resDoneCount), 32'd1);
    checkOutput("ignStartBusyAfter", 32'(resBusyLater), 32'd0);
    checkOutput("ignStartPass", 32'(resPass), 32'd1);
    checkOutput("ignStartChain", 32'(chainA), 32'h000F3CA5);

    // Reset during the shift of bit 11 (cycle 13)
    @(negedge clk);
    startA = 1'b1;
    @(negedge clk);
    startA  = 1'b0;
    sValidA = 1'b1;
    sDataA  = 8'hA5;
    @(negedge clk);
    sDataA = 8'h3C;
    repeat (11) @(negedge clk);
    checkOutput("midLoadShiftEn", 32'(shiftEnA), 32'd1);
    #1 rstN = 1'b0;
    #1;
    checkOutput("midRstShiftEn", 32'(shiftEnA), 32'd0);
    checkOutput("midRstBusy", 32'(busyA), 32'd0);
    checkOutput("midRstReady", 32'(sReadyA), 32'd0);
    checkOutput("midRstHead", 32'(headA), 32'd0);
    sValidA = 1'b0;
    @(negedge clk);
    rstN = 1'b1;

    applyStimulus(0, 0);
    checkOutput("postRstDoneCycle", 32'(resDoneCycle), 32'd42);
    checkOutput("postRstPass", 32'(resPass), 32'd1);
    checkOutput("postRstChain", 32'(chainA), 32'h000F3CA5);

    // 8-flop chain, one byte: s_ready only in cycle 1, done at 2*8+2
    readyCnt   = 0;
    shiftCnt   = 0;
    doneCyc    = 0;
    passAtDone = 1'bx;
    @(negedge clk);
    startB = 1'b1;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        startB  = 1'b0;
        sValidB = 1'b1;
        sDataB  = 8'h81;
      end
      if (cyc == 2) sValidB = 1'b0;
      if (sReadyB) readyCnt++;
      if (shiftEnB) shiftCnt++;
      if (doneB && doneCyc == 0) begin
        doneCyc    = cyc;
        passAtDone = passB;
      end
    end
    checkOutput("oneByteReadyCycles", 32'(readyCnt), 32'd1);
    checkOutput("oneByteShifts", 32'(shiftCnt), 32'd16);
    checkOutput("oneByteDoneCycle", 32'(doneCyc), 32'd18);
    checkOutput("oneBytePass", 32'(passAtDone), 32'd1);
    checkOutput("oneByteChain", 32'(chainB), 32'h00000081);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
